// File: rtl/serial_addsub_pkg.sv
// rtl/serial_addsub_pkg.sv - shared types and constants for the bit-serial adder/subtractor
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/serial_addsub_if.sv
// rtl/serial_addsub_if.sv - start/busy/done operand and result bundle
interface serial_addsub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;

  modport master (
    output start, mode, a, b,
    input  busy, done, result, carry_out
  );

  modport slave (
    input  start, mode, a, b,
    output busy, done, result, carry_out
  );
endinterface

// File: rtl/serial_addsub_fa_cell.sv
// rtl/serial_addsub_fa_cell.sv - combinational 1-bit full adder
module fa_cell (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);

  // Sum and carry of three input bits
  always_comb begin
    s    = x ^ y ^ cin;
    cout = (x & y) | (cin & (x ^ y));
  end

endmodule

// File: rtl/serial_addsub.sv
// rtl/serial_addsub.sv - bit-serial add/subtract, one operand bit per clock, LSB first
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  serial_addsub_if.slave  bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             accept;
  logic             fa_s, fa_cout;

  // Subtraction feeds the inverted b bit; the +1 comes from the initial carry
  fa_cell u_fa (
    .x    (a_sh_q[0]),
    .y    (b_sh_q[0] ^ mode_q),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  // State and datapath registers; reset clears everything including the visible result
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      mode_q   <= 1'b0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
    end
  end

  // Next state and datapath: shift one bit per RUN cycle, publish result on entry to DONE
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    accept   = bus.start && (state_q == IDLE || state_q == DONE);

    case (state_q)
      RUN: begin
        res_sh_d = {fa_s, res_sh_q[WIDTH-1:1]};
        carry_d  = fa_cout;
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          state_d  = DONE;
          result_d = {fa_s, res_sh_q[WIDTH-1:1]};
          cout_d   = (mode_q == MODE_SUB) ? ~fa_cout : fa_cout;
        end
      end
      DONE:    state_d = IDLE;
      IDLE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Capture overrides the DONE->IDLE return so back-to-back operations lose no cycle
    if (accept) begin
      state_d  = RUN;
      a_sh_d   = bus.a;
      b_sh_d   = bus.b;
      mode_d   = bus.mode;
      carry_d  = (bus.mode == MODE_SUB);
      cnt_d    = '0;
      res_sh_d = '0;
    end
  end

  assign bus.busy      = (state_q == RUN);
  assign bus.done      = (state_q == DONE);
  assign bus.result    = result_q;
  assign bus.carry_out = cout_q;

endmodule

// File: tb/tb_serial_addsub.sv
// tb/tb_serial_addsub.sv - self-checking bench for serial_addsub at WIDTH 8 and WIDTH 2
module tb_serial_addsub;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_addsub_if #(.WIDTH(8)) if8 ();
  serial_addsub_if #(.WIDTH(2)) if2 ();

  serial_addsub #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8.slave));
  serial_addsub #(.WIDTH(2)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic modulo 2^w, borrow when a < b
  task automatic ref_calc(input int w, input int ra, input int rb, input bit rm,
                          output int r, output int c);
    int full;
    full = 1 << w;
    if (rm) begin
      r = (ra - rb + full) % full;
      c = (ra < rb) ? 1 : 0;
    end else begin
      r = (ra + rb) % full;
      c = ((ra + rb) >= full) ? 1 : 0;
    end
  endtask

  // Issue one operation on the 8-bit unit; returns at the negedge of the done cycle
  task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic tm,
                     output int lat, output int busy_cnt);
    @(negedge clk);
    if8.start = 1'b1; if8.a = ta; if8.b = tb; if8.mode = tm;
    @(negedge clk);
    if8.start = 1'b0;
    lat = 1; busy_cnt = 0;
    while (if8.done !== 1'b1 && lat < 40) begin
      if (if8.busy === 1'b1) busy_cnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic op2(input logic [1:0] ta, input logic [1:0] tb, input logic tm, output int lat);
    @(negedge clk);
    if2.start = 1'b1; if2.a = ta; if2.b = tb; if2.mode = tm;
    @(negedge clk);
    if2.start = 1'b0;
    lat = 1;
    while (if2.done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat, bc, er, ec, cnt_done, cnt_busy, gap;
    logic [7:0] ra, rb;
    logic rm;

    if8.start = 1'b0; if8.mode = 1'b0; if8.a = '0; if8.b = '0;
    if2.start = 1'b0; if2.mode = 1'b0; if2.a = '0; if2.b = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_busy", if8.busy, 0);
    check("reset_done", if8.done, 0);
    check("reset_result", if8.result, 0);
    check("reset_carry", if8.carry_out, 0);
    rst = 1'b0;

    op8(8'h5A, 8'h3C, 1'b0, lat, bc);
    check("add5a3c_latency", lat, 9);
    check("add5a3c_busy_cycles", bc, 8);
    check("add5a3c_result", if8.result, 8'h96);
    check("add5a3c_carry", if8.carry_out, 0);
    @(negedge clk);
    check("done_one_cycle", if8.done, 0);
    check("result_held", if8.result, 8'h96);

    op8(8'hFF, 8'h01, 1'b0, lat, bc);
    check("addff01_result", if8.result, 8'h00);
    check("addff01_carry", if8.carry_out, 1);

    op8(8'h10, 8'h01, 1'b1, lat, bc);
    check("sub1001_result", if8.result, 8'h0F);
    check("sub1001_borrow", if8.carry_out, 0);

    op8(8'h01, 8'h02, 1'b1, lat, bc);
    check("sub0102_result", if8.result, 8'hFF);
    check("sub0102_borrow", if8.carry_out, 1);

    // start pulsed mid-RUN must be ignored
    @(negedge clk);
    if8.start = 1'b1; if8.a = 8'h12; if8.b = 8'h34; if8.mode = 1'b0;
    @(negedge clk);
    if8.start = 1'b0;
    repeat (2) @(negedge clk);
    if8.start = 1'b1; if8.a = 8'h00; if8.b = 8'h00;
    @(negedge clk);
    if8.start = 1'b0;
    lat = 0;
    while (if8.done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("ignore_start_done_seen", if8.done, 1);
    check("ignore_start_result", if8.result, 8'h46);
    check("ignore_start_carry", if8.carry_out, 0);
    cnt_done = 0; cnt_busy = 0;
    repeat (12) begin
      @(negedge clk);
      if (if8.done === 1'b1) cnt_done++;
      if (if8.busy === 1'b1) cnt_busy++;
    end
    check("ignore_start_no_second_done", cnt_done, 0);
    check("ignore_start_no_second_busy", cnt_busy, 0);

    // reset during RUN aborts without a done pulse
    @(negedge clk);
    if8.start = 1'b1; if8.a = 8'h77; if8.b = 8'h11; if8.mode = 1'b0;
    @(negedge clk);
    if8.start = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_busy_before_reset", if8.busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", if8.busy, 0);
    check("abort_done", if8.done, 0);
    check("abort_result", if8.result, 0);
    check("abort_carry", if8.carry_out, 0);
    cnt_done = 0;
    repeat (12) begin
      @(negedge clk);
      if (if8.done === 1'b1) cnt_done++;
    end
    check("abort_no_done", cnt_done, 0);

    // back-to-back: start held through the done cycle
    @(negedge clk);
    if8.start = 1'b1; if8.a = 8'h01; if8.b = 8'h01; if8.mode = 1'b0;
    @(negedge clk);
    if8.a = 8'h03; if8.b = 8'h02; if8.mode = 1'b1;
    lat = 1;
    while (if8.done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("b2b_first_latency", lat, 9);
    check("b2b_first_result", if8.result, 8'h02);
    @(negedge clk);
    if8.start = 1'b0;
    gap = 1;
    while (if8.done !== 1'b1 && gap < 40) begin
      @(negedge clk);
      gap++;
    end
    check("b2b_second_gap", gap, 9);
    check("b2b_second_result", if8.result, 8'h01);
    check("b2b_second_carry", if8.carry_out, 0);

    // random operands against the arithmetic model
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rm = 1'($urandom_range(0, 1));
      op8(ra, rb, rm, lat, bc);
      ref_calc(8, int'(ra), int'(rb), rm, er, ec);
      check($sformatf("rand%0d_latency", i), lat, 9);
      check($sformatf("rand%0d_result a=%0h b=%0h m=%0d", i, ra, rb, rm), if8.result, er);
      check($sformatf("rand%0d_carry a=%0h b=%0h m=%0d", i, ra, rb, rm), if8.carry_out, ec);
    end

    // exhaustive 2-bit sweep
    for (int m = 0; m < 2; m++) begin
      for (int x = 0; x < 4; x++) begin
        for (int y = 0; y < 4; y++) begin
          op2(2'(x), 2'(y), 1'(m), lat);
          ref_calc(2, x, y, 1'(m), er, ec);
          check($sformatf("w2_latency a=%0d b=%0d m=%0d", x, y, m), lat, 3);
          check($sformatf("w2_result a=%0d b=%0d m=%0d", x, y, m), if2.result, er);
          check($sformatf("w2_carry a=%0d b=%0d m=%0d", x, y, m), if2.carry_out, ec);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
